// File: rtl/timer_pkg.sv
// Shared types and constants for the two-digit BCD countdown timer.
// State HOLD is only reachable when TIMER_AUTORELOAD_EN is defined.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } timer_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Out-of-range nibbles (A-F) saturate to 9 so the digits stay decodable.
  function automatic bcd_digit_t bcd_clamp(input logic [3:0] nib);
    return (nib > BCD_MAX) ? BCD_MAX : bcd_digit_t'(nib);
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The count is frozen (not reset) while enable is low, so a pause stretches
// the current period by exactly the paused cycles. clear has priority and
// suppresses the tick of that cycle.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Terminal-count detect and next count value.
  always_comb begin
    tick  = enable && !clear && (cnt_q == CNT_LAST);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Two-digit BCD down-counter driving the tens/ones seven-segment decoders.
// Optional feature macro: TIMER_AUTORELOAD_EN
//   defined   : expiry parks in HOLD showing 00 for one tick period, then
//               reloads the last preset and keeps counting (running stays 1).
//   undefined : expiry returns to IDLE and waits for a new load.
//
// state | meaning
// IDLE  | not counting, digits hold, prescaler held at 0
// RUN   | counting down one step per prescaler tick
// HOLD  | showing 00 for one tick before auto-reload (macro builds only)
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       enable,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired
);

  timer_state_e state_q, state_d;
  bcd_digit_t   tens_q, tens_d;
  bcd_digit_t   ones_q, ones_d;
  bcd_digit_t   rld_tens_q, rld_tens_d;
  bcd_digit_t   rld_ones_q, rld_ones_d;
  logic         running_q, running_d;
  logic         expired_q, expired_d;

  bcd_digit_t   ld_tens, ld_ones;
  logic         ld_nonzero;
  logic         pre_en, pre_clr, tick;

  assign ld_tens    = bcd_clamp(load_val[7:4]);
  assign ld_ones    = bcd_clamp(load_val[3:0]);
  assign ld_nonzero = (ld_tens != '0) || (ld_ones != '0);

  // The prescaler only runs while counting; a load restarts the step period.
  assign pre_en  = enable && (state_q != IDLE);
  assign pre_clr = load || (state_q == IDLE);

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pre_en),
    .clear  (pre_clr),
    .tick   (tick)
  );

  // Next-state, digit update and expiry decode; load overrides any tick.
  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    rld_tens_d = rld_tens_q;
    rld_ones_d = rld_ones_q;
    expired_d  = 1'b0;

    if (load) begin
      tens_d     = ld_tens;
      ones_d     = ld_ones;
      rld_tens_d = ld_tens;
      rld_ones_d = ld_ones;
      state_d    = ld_nonzero ? RUN : IDLE;
    end else if (tick) begin
      case (state_q)
        RUN: begin
          if ((tens_q == '0) && (ones_q == '0)) begin
            // Never underflow; a stray 00 in RUN simply stops.
            state_d = IDLE;
          end else begin
            if (ones_q != '0) begin
              ones_d = ones_q - 4'd1;
            end else begin
              ones_d = BCD_MAX;
              tens_d = tens_q - 4'd1;
            end
            if ((tens_q == '0) && (ones_q == 4'd1)) begin
              expired_d = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
              state_d   = HOLD;
`else
              state_d   = IDLE;
`endif
            end
          end
        end
        HOLD: begin
          tens_d = rld_tens_q;
          ones_d = rld_ones_q;
`ifdef TIMER_AUTORELOAD_EN
          state_d = RUN;
`else
          // HOLD is unreachable here; fall back to a parked preset.
          state_d = IDLE;
`endif
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    running_d = (state_d != IDLE);
  end

  // State, digit and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tens_q     <= '0;
      ones_q     <= '0;
      rld_tens_q <= '0;
      rld_ones_q <= '0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      rld_tens_q <= rld_tens_d;
      rld_ones_q <= rld_ones_d;
      running_q  <= running_d;
      expired_q  <= expired_d;
    end
  end

  assign tens    = tens_q;
  assign ones    = ones_q;
  assign running = running_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer with TICK_DIV=4.
// Stimulus pushes every expected output change (value and edge number);
// the monitor pops one entry whenever the DUT outputs change.
module tb_bcd_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       load;
  logic [7:0] load_val;
  logic       enable;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       running;
  logic       expired;

  bcd_countdown_timer #(
    .TICK_DIV (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .enable   (enable),
    .tens     (tens),
    .ones     (ones),
    .running  (running),
    .expired  (expired)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] t;
    logic [3:0] o;
    logic       r;
    logic       e;
  } exp_t;

  exp_t q[$];
  exp_t exp_cur;

  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   done = 1'b0;
  bit   finished = 1'b0;

  // Push an expected output tuple, but only when it differs from the last one.
  task automatic push_exp(input int c, input logic [3:0] t, input logic [3:0] o,
                          input logic r, input logic e);
    exp_t x;
    x.cyc = c; x.t = t; x.o = o; x.r = r; x.e = e;
    if ({t, o, r, e} != {exp_cur.t, exp_cur.o, exp_cur.r, exp_cur.e}) begin
      q.push_back(x);
      exp_cur = x;
    end
  endtask

  // One-cycle load strobe from a falling edge; returns the load edge number.
  task automatic load_at(input logic [7:0] v, input logic [3:0] et,
                         input logic [3:0] eo, output int l);
    l = cyc + 1;
    push_exp(l, et, eo, (et != 0) || (eo != 0), 1'b0);
    load     = 1'b1;
    load_val = v;
    @(negedge clk);
    load     = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: reset check, then one scoreboard comparison per output change.
  logic [9:0] prev;
  logic [9:0] cur;
  bit         started = 1'b0;
  exp_t       m_e;
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {tens, ones, running, expired};
      if (!started) begin
        started = 1'b1;
        checks++;
        if (cur != 10'd0) begin
          errors++;
          $display("FAIL reset_state: got t=%0d o=%0d run=%0b exp=%0b, expected all zero",
                   tens, ones, running, expired);
        end
        prev = cur;
      end else if (cur != prev) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change at edge %0d: got t=%0d o=%0d run=%0b exp=%0b, expected no change",
                   cyc, tens, ones, running, expired);
        end else begin
          m_e = q.pop_front();
          if (m_e.cyc != cyc || m_e.t != tens || m_e.o != ones ||
              m_e.r != running || m_e.e != expired) begin
            errors++;
            $display("FAIL output_event: got edge %0d t=%0d o=%0d run=%0b exp=%0b, expected edge %0d t=%0d o=%0d run=%0b exp=%0b",
                     cyc, tens, ones, running, expired,
                     m_e.cyc, m_e.t, m_e.o, m_e.r, m_e.e);
          end
        end
        prev = cur;
      end
      if (done && !finished) begin
        checks++;
        if (q.size() != 0) begin
          errors++;
          $display("FAIL missing_events: got %0d expected changes never seen, expected 0 (next edge %0d t=%0d o=%0d)",
                   q.size(), q[0].cyc, q[0].t, q[0].o);
        end
        finished = 1'b1;
      end
    end
  end

  initial begin
    int l;
    int l2;
    rst_n    = 1'b0;
    load     = 1'b0;
    load_val = 8'h00;
    enable   = 1'b0;
    exp_cur.cyc = 0; exp_cur.t = 4'd0; exp_cur.o = 4'd0;
    exp_cur.r = 1'b0; exp_cur.e = 1'b0;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Reset mid-count: 25 -> 24 -> 23, reset at edge l+11.
    load_at(8'h25, 4'd2, 4'd5, l);
    push_exp(l + 4, 4'd2, 4'd4, 1'b1, 1'b0);
    push_exp(l + 8, 4'd2, 4'd3, 1'b1, 1'b0);
    wait_until(l + 10);
    push_exp(l + 11, 4'd0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Borrow: 12, 11, 10, 09.
    load_at(8'h12, 4'd1, 4'd2, l);
    push_exp(l + 4,  4'd1, 4'd1, 1'b1, 1'b0);
    push_exp(l + 8,  4'd1, 4'd0, 1'b1, 1'b0);
    push_exp(l + 12, 4'd0, 4'd9, 1'b1, 1'b0);
    wait_until(l + 14);

    // Expiry from 02.
    load_at(8'h02, 4'd0, 4'd2, l);
    push_exp(l + 4, 4'd0, 4'd1, 1'b1, 1'b0);
`ifdef TIMER_AUTORELOAD_EN
    push_exp(l + 8,  4'd0, 4'd0, 1'b1, 1'b1);
    push_exp(l + 9,  4'd0, 4'd0, 1'b1, 1'b0);
    push_exp(l + 12, 4'd0, 4'd2, 1'b1, 1'b0);
    push_exp(l + 16, 4'd0, 4'd1, 1'b1, 1'b0);
    push_exp(l + 20, 4'd0, 4'd0, 1'b1, 1'b1);
    push_exp(l + 21, 4'd0, 4'd0, 1'b1, 1'b0);
`else
    push_exp(l + 8,  4'd0, 4'd0, 1'b0, 1'b1);
    push_exp(l + 9,  4'd0, 4'd0, 1'b0, 1'b0);
`endif
    wait_until(l + 22);

    // Clamping, then load 00 goes idle with no expiry pulse.
    load_at(8'h3C, 4'd3, 4'd9, l);
    load_at(8'hF7, 4'd9, 4'd7, l);
    load_at(8'h00, 4'd0, 4'd0, l);
    wait_until(l + 9);

    // Pause: enable low for 3 edges with prescaler at 2 -> step at l+7.
    load_at(8'h05, 4'd0, 4'd5, l);
    push_exp(l + 7,  4'd0, 4'd4, 1'b1, 1'b0);
    push_exp(l + 11, 4'd0, 4'd3, 1'b1, 1'b0);
    wait_until(l + 2);
    enable = 1'b0;
    wait_until(l + 5);
    enable = 1'b1;
    wait_until(l + 12);

    // Load on the tick edge at 07: 30 wins, then 29 and 28 at 4-edge steps.
    load_at(8'h07, 4'd0, 4'd7, l);
    wait_until(l + 3);
    load_at(8'h30, 4'd3, 4'd0, l2);
    push_exp(l2 + 4, 4'd2, 4'd9, 1'b1, 1'b0);
    push_exp(l2 + 8, 4'd2, 4'd8, 1'b1, 1'b0);
    wait_until(l2 + 9);

    done = 1'b1;
    for (int i = 0; i < 10 && !finished; i++) @(negedge clk);
    if (!finished) begin
      $display("FAIL monitor_done: got no final report, expected one");
      $fatal(1, "monitor did not complete");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
